// File: rtl/gray_sync_decoder.sv
// gray_sync_decoder
//   Brings an asynchronous Gray-coded input into the clk domain through a
//   two-flop synchronizer. It decodes the synchronized code to binary and
//   reports every change of the decoded value. Each change gives a one-cycle
//   out_valid pulse, together with the step direction and an illegal-step
//   flag.
//
//   Sequence after reset:
//     FILL  (2 cycles) flushes the synchronizer.
//     LOAD  (1 cycle)  takes the first value without checking it.
//     TRACK            runs until the next reset.
//
// Parameters
//   WIDTH         code width in bits, legal range 2..8.
//
// Ports
//   clk           single clock, rising edge.
//   rst           asynchronous, active-high reset.
//   in_gray       Gray-coded input, asynchronous to clk.
//   out_binary    registered decoded value.
//   out_valid     one-cycle pulse when out_binary takes a new value.
//   out_dir       1 = step up, 0 = step down. Meaningful only when
//                 out_valid=1 and out_step_err=0.
//   out_step_err  one-cycle pulse, coincident with out_valid. Set when the
//                 new value is neither last+1 nor last-1 (mod 2^WIDTH).
//   err_count     saturating count of illegal steps.
//
// Build option
//   GRAY_ERR_COUNT_EN  when defined, err_count counts out_step_err pulses and
//                      saturates at 255. When undefined, err_count is
//                      constant 0 and no counter is built.
module gray_sync_decoder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_gray,
  output logic [WIDTH-1:0] out_binary,
  output logic             out_valid,
  output logic             out_dir,
  output logic             out_step_err,
  output logic [7:0]       err_count
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    LOAD  = 2'd1,
    TRACK = 2'd2
  } state_t;

  state_t           state, state_next;
  logic             fill_cnt;
  logic [WIDTH-1:0] s1, s2;
  logic [WIDTH-1:0] last;
  logic [WIDTH-1:0] decoded;
  logic [WIDTH-1:0] step;

  logic [WIDTH-1:0] binary_d, last_d;
  logic             valid_d, dir_d, step_err_d;

  // MSB passes straight through; each lower bit XORs the Gray bit with the
  // binary bit above it.
  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Two-flop synchronizer; only s2 is seen by the decode logic.
  // NOTE: flops use non-blocking assignments so that s2 takes the old s1,
  // not the value s1 receives on this same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= in_gray;
      s2 <= s1;
    end
  end

  assign decoded = gray_to_bin(s2);
  // Modular difference: 1 is an up step and all-ones is a down step. This
  // also covers wrap-around.
  assign step    = decoded - last;

  // State register. fill_cnt marks the second FILL cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FILL;
      fill_cnt <= 1'b0;
    end else begin
      state    <= state_next;
      fill_cnt <= (state == FILL);
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (fill_cnt) state_next = LOAD;
      LOAD:    state_next = TRACK;
      TRACK:   state_next = TRACK;
      default: state_next = FILL;
    endcase
  end

  // Output logic: next values for the registered outputs.
  // NOTE: every output gets a default before the case statement, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    binary_d   = out_binary;
    last_d     = last;
    valid_d    = 1'b0;
    step_err_d = 1'b0;
    dir_d      = out_dir;
    case (state)
      LOAD: begin
        binary_d = decoded;
        last_d   = decoded;
        valid_d  = 1'b1;
        dir_d    = 1'b0;
      end
      TRACK: begin
        if (decoded != last) begin
          binary_d = decoded;
          last_d   = decoded;
          valid_d  = 1'b1;
          if (step == WIDTH'(1)) begin
            dir_d = 1'b1;
          end else if (step == '1) begin
            dir_d = 1'b0;
          end else begin
            dir_d      = 1'b0;
            step_err_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_binary   <= '0;
      last         <= '0;
      out_valid    <= 1'b0;
      out_dir      <= 1'b0;
      out_step_err <= 1'b0;
    end else begin
      out_binary   <= binary_d;
      last         <= last_d;
      out_valid    <= valid_d;
      out_dir      <= dir_d;
      out_step_err <= step_err_d;
    end
  end

`ifdef GRAY_ERR_COUNT_EN
  // Updates on the same edge that raises out_step_err, so the pulse and the
  // new count are visible together.
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= 8'd0;
    end else if (step_err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_gray_sync_decoder.sv
// Self-checking bench for gray_sync_decoder (WIDTH=4).
// The stimulus process drives in_gray once per cycle on the falling edge. A
// reference model turns each sampled value into an expected output event.
// That event carries the cycle it is due and is pushed into a scoreboard
// queue. A monitor process, also on the falling edge, pops and compares the
// events whenever out_valid is seen. Between pulses it checks that the
// outputs hold.
module tb_gray_sync_decoder;

  localparam int W    = 4;
  localparam int NVAL = 1 << W;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] in_gray = '0;
  logic [W-1:0] out_binary;
  logic         out_valid;
  logic         out_dir;
  logic         out_step_err;
  logic [7:0]   err_count;

  gray_sync_decoder #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_gray      (in_gray),
    .out_binary   (out_binary),
    .out_valid    (out_valid),
    .out_dir      (out_dir),
    .out_step_err (out_step_err),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    int due;
    int bin;
    int dir;
    int err;
    int cnt;
  } exp_t;

  exp_t q[$];

  // Reference model state.
  int  p      = 0;  // edges sampled since reset release
  int  m_last = 0;
  int  m_cnt  = 0;

  // Values the monitor expects the outputs to hold between pulses.
  int  h_bin = 0;
  int  h_dir = 0;
  int  h_cnt = 0;

  // Binary value of a Gray code: XOR of all right shifts of the code.
  function automatic int to_bin(input int g);
    int b = 0;
    for (int s = g; s != 0; s = s >> 1) b ^= s;
    return b % NVAL;
  endfunction

  function automatic int to_gray(input int b);
    return (b ^ (b >> 1)) % NVAL;
  endfunction

  function automatic int bump(input int c);
`ifdef GRAY_ERR_COUNT_EN
    return (c < 255) ? c + 1 : 255;
`else
    return 0;
`endif
  endfunction

  // Must be called on a falling edge. Drives one code for one cycle and
  // records the response the model predicts for the next rising edge.
  task automatic drive(input int g);
    int   bin, d;
    exp_t e;
    in_gray = W'(g);
    p++;
    bin = to_bin(g);
    // A value sampled at rising edge N reaches out_binary on edge N+2.
    e.due = cyc + 3;
    if (p == 1) begin
      e.bin = bin; e.dir = 0; e.err = 0; e.cnt = m_cnt;
      q.push_back(e);
      m_last = bin;
    end else if (bin != m_last) begin
      d = (bin - m_last + NVAL) % NVAL;
      e.bin = bin;
      if (d == 1) begin
        e.dir = 1; e.err = 0;
      end else if (d == NVAL - 1) begin
        e.dir = 0; e.err = 0;
      end else begin
        e.dir = 0; e.err = 1;
        m_cnt = bump(m_cnt);
      end
      e.cnt = m_cnt;
      q.push_back(e);
      m_last = bin;
    end
    @(negedge clk);
  endtask

  task automatic hold(input int g, input int n);
    for (int i = 0; i < n; i++) drive(g);
  endtask

  // Asserts reset 2 time units after a rising edge. Checks that the outputs
  // clear without waiting for a clock, then releases reset on a falling edge.
  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_binary",   out_binary,   0);
    check("rst_valid",    out_valid,    0);
    check("rst_dir",      out_dir,      0);
    check("rst_step_err", out_step_err, 0);
    check("rst_err_count", err_count,   0);
    q.delete();
    p = 0; m_last = 0; m_cnt = 0;
    h_bin = 0; h_dir = 0; h_cnt = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      while (q.size() > 0 && q[0].due < cyc) begin
        check("missing_pulse", 0, 1);
        void'(q.pop_front());
      end
      if (out_valid) begin
        if (q.size() > 0 && q[0].due == cyc) begin
          e = q.pop_front();
          check("pulse_binary",    out_binary,   e.bin);
          check("pulse_dir",       out_dir,      e.dir);
          check("pulse_step_err",  out_step_err, e.err);
          check("pulse_err_count", err_count,    e.cnt);
          h_bin = e.bin; h_dir = e.dir; h_cnt = e.cnt;
        end else begin
          check("spurious_valid", out_valid, 0);
        end
      end else begin
        if (q.size() > 0 && q[0].due == cyc) begin
          check("valid_due", out_valid, 1);
          void'(q.pop_front());
        end
        check("hold_binary",    out_binary,   h_bin);
        check("hold_dir",       out_dir,      h_dir);
        check("hold_err_count", err_count,    h_cnt);
        check("idle_step_err",  out_step_err, 0);
      end
    end
  end

  initial begin
    int b;
    int r;
    int n;

    // Reset, then zero held: exactly one load pulse with value 0.
    do_reset();
    hold(0, 8);

    // Up-count through Gray codes 0000, 0001, 0011, 0010.
    hold(1, 5);
    hold(3, 5);
    hold(2, 5);

    // Reset in mid-cycle while out_binary=3. Reload, no error.
    do_reset();
    hold(2, 6);

    // Wrap-around both ways: 15 -> 0 (up), then 0 -> 15 (down).
    do_reset();
    hold(8, 6);
    hold(0, 5);
    hold(8, 5);

    // Illegal step 0 -> 4.
    hold(0, 5);
    hold(6, 5);

    // 300 alternations 0000 <-> 0110, one change every other cycle.
    for (int i = 0; i < 300; i++) hold((i % 2 == 0) ? 0 : 6, 2);
    hold(6, 4);
`ifdef GRAY_ERR_COUNT_EN
    check("err_count_saturated", err_count, 255);
`else
    check("err_count_disabled", err_count, 0);
`endif

    // Back-to-back changes, one on every cycle.
    do_reset();
    hold(0, 4);
    for (int i = 1; i <= 20; i++) drive(to_gray(i % NVAL));

    // Random walk: mostly legal steps, some holds and jumps, and
    // occasional resets.
    b = to_bin(int'(in_gray));
    for (int k = 0; k < 1200; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end
      r = $urandom_range(0, 9);
      if (r < 4)       b = (b + 1) % NVAL;
      else if (r < 7)  b = (b + NVAL - 1) % NVAL;
      else if (r < 9)  b = b;
      else             b = $urandom_range(0, NVAL - 1);
      n = $urandom_range(1, 3);
      hold(to_gray(b), n);
    end

    // Drain in-flight events.
    hold(to_gray(b), 5);
    check("scoreboard_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gray_sync_decoder.md
GRAY_SYNC_DECODER -- requirements
Module: gray_sync_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the code width in bits; legal range is 2 to 8.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port in_gray, input, WIDTH bits: a Gray-coded value, asynchronous to clk.
REQ-005 SHALL have port out_binary, output, WIDTH bits: the decoded binary value, registered.
REQ-006 SHALL have port out_valid, output, 1 bit: a one-cycle pulse when out_binary takes a new value.
REQ-007 SHALL have port out_dir, output, 1 bit: 1 = step up, 0 = step down; meaningful only when out_valid=1 and out_step_err=0.
REQ-008 SHALL have port out_step_err, output, 1 bit: a one-cycle pulse, coincident with out_valid, flagging an illegal step.
REQ-009 SHALL have port err_count, output, 8 bits: the saturating count of illegal steps.

Function
REQ-010 SHALL pass in_gray through a two-flop synchronizer (s1, s2); only s2 is used downstream.
REQ-011 SHALL decode s2 to binary: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] XOR g[i].
REQ-012 SHALL implement the FSM states FILL, LOAD and TRACK.
- FILL: 2 cycles, flushing the synchronizer; no outputs change.
- LOAD: 1 cycle; registers decode(s2) into out_binary and last, pulses out_valid; out_step_err=0, out_dir=0; next state TRACK.
- TRACK: stays in TRACK until reset.
REQ-013 SHALL, in TRACK, when decode(s2) != last, update out_binary and last, pulse out_valid, and classify the step.
- new = last+1 mod 2^WIDTH: out_dir=1.
- new = last-1 mod 2^WIDTH: out_dir=0.
- otherwise: out_step_err=1, out_dir=0.
REQ-014 SHALL hold all outputs except the pulses, and raise no pulses, when decode(s2) equals last.
REQ-015 SHALL have a latency of 3 edges: a value stable on in_gray at edge N appears on out_binary after edge N+2, with out_valid high for that one cycle.
REQ-016 SHALL treat wrap-around (2^WIDTH-1 to 0 up, 0 to 2^WIDTH-1 down) as a legal step.
REQ-017 SHALL load whatever s2 holds in LOAD when in_gray changes during FILL, without an error check.
REQ-018 SHALL detect a change on every cycle; consecutive cycles may each produce a valid pulse.

Reset
REQ-019 SHALL on rst=1 immediately clear s1, s2, last, out_binary, out_valid, out_dir, out_step_err and err_count to 0, and enter FILL.
REQ-020 SHALL, when rst is asserted mid-operation, discard all history; after release the FILL/LOAD sequence repeats and the first loaded value is never flagged.

Configuration
REQ-021 SHALL, with macro GRAY_ERR_COUNT_EN defined, increment err_count by 1 on each out_step_err pulse, saturating at 255.
REQ-022 SHALL, without GRAY_ERR_COUNT_EN, keep the err_count port present, drive it constant 0, and compile in no counter logic.

Verification
REQ-023 SHALL cover: rst pulse, in_gray=0000 held -> after 3rd edge post-release out_valid=1 once, out_binary=0000, out_step_err=0.
REQ-024 SHALL cover: in_gray 0000->0001->0011->0010, 5 cycles apart -> 3 valid pulses, out_binary 1,2,3, out_dir=1, no errors.
REQ-025 SHALL cover: in_gray 1000 (bin 15) -> 0000 -> out_binary=0, out_dir=1; then 0000 -> 1000 -> out_binary=15, out_dir=0, no errors.
REQ-026 SHALL cover: in_gray 0000 -> 0110 (bin 4) -> out_valid=1, out_step_err=1, out_binary=4, err_count=1 (GRAY_ERR_COUNT_EN defined).
REQ-027 SHALL cover: 300 alternations 0000<->0110 -> err_count=255 with the macro; err_count=0 without it.
REQ-028 SHALL cover: rst asserted mid-cycle while out_binary=3 -> all outputs 0 before the next edge; after release out_binary reloads via LOAD with no error.
